// File: rtl/stream_arb_pkg.sv
// Shared state encoding, width helper and default throttle level for the stream FIFO arbiter.
package stream_arb_pkg;

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_ARB   = 1'b0;
    localparam arb_state_t ST_GRANT = 1'b1;

    localparam int DEF_DEPTH    = 16384;
    localparam int DEF_HEADROOM = 4;
    localparam int THROTTLE_LVL = DEF_DEPTH - DEF_HEADROOM;

    // Index width for n items; a single bit is kept even for n <= 2.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first set request at or after start_i, wrapping modulo N.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = id_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Wrap by explicit compare so non-power-of-two N never aliases onto invalid lanes.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDX_W'(sum);
    endfunction

    logic [IDX_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = wrap_idx(start_i, k);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_fifo_rr_arbiter.sv
// Round-robin, burst-limited merge of N_IN AXI-Stream lanes into one FIFO input with almost-full throttling.
// Optional per-lane beat and throttle-cycle statistics are enabled with `define STREAM_ARB_STATS_EN.
module stream_fifo_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_IN      = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = 14,
    parameter int BURST_LEN = 16,
    parameter int HEADROOM  = DEF_HEADROOM,
    parameter int ID_W      = id_width(N_IN)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [N_IN*WIDTH-1:0] in_tdata,
    input  logic [N_IN-1:0]       in_tvalid,
    output logic [N_IN-1:0]       in_tready,
    output logic [WIDTH-1:0]      fifo_tdata,
    output logic [ID_W-1:0]       fifo_tid,
    output logic                  fifo_tvalid,
    input  logic                  fifo_tready,
    input  logic [CNT_W-1:0]      fifo_count,
    output logic [ID_W-1:0]       grant_idx,
    output logic                  throttled
`ifdef STREAM_ARB_STATS_EN
    ,
    output logic [N_IN*32-1:0]    beat_cnt_all,
    output logic [31:0]           throttle_cycles
`endif
);

    localparam int BC_W = id_width(BURST_LEN);
    localparam int TC_W = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0]  LAST_BEAT   = BC_W'(BURST_LEN - 1);
    localparam logic [TC_W-1:0]  STARVE_AT   = TC_W'(BURST_LEN);
    localparam logic [CNT_W:0]   THROTTLE_AT = (CNT_W + 1)'(DEPTH - HEADROOM);

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [BC_W-1:0]  beat_q, beat_d;
    logic [TC_W-1:0]  thr_cnt_q, thr_cnt_d;
    logic             throttled_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [ID_W-1:0]  out_tid_q;

    logic [WIDTH-1:0] lane [N_IN];
    logic [ID_W-1:0]  arb_start;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic             out_free;
    logic             can_take;
    logic             accept;
    logic             starve_release;

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        assign lane[i] = in_tdata[i*WIDTH +: WIDTH];
    end

    assign arb_start = (grant_q == ID_W'(N_IN - 1)) ? '0 : grant_q + ID_W'(1);

    rr_pick #(
        .N     (N_IN),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i   (in_tvalid),
        .start_i (arb_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign out_free       = !out_valid_q || fifo_tready;
    assign can_take       = out_free && !throttled_q;
    assign starve_release = (state_q == ST_GRANT) && throttled_q && (thr_cnt_q == STARVE_AT);

    // Ready is also gated by reset so a beat presented in the reset cycle is never taken.
    always_comb begin
        in_tready = '0;
        if ((state_q == ST_GRANT) && can_take && !ap_rst) begin
            in_tready[grant_q] = 1'b1;
        end
    end

    assign accept = |(in_tvalid & in_tready);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        beat_d    = beat_q;
        thr_cnt_d = '0;
        if ((state_q == ST_GRANT) && throttled_q) begin
            thr_cnt_d = (thr_cnt_q == STARVE_AT) ? thr_cnt_q : thr_cnt_q + TC_W'(1);
        end
        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    beat_d = beat_q + BC_W'(1);
                end
                if (accept && (beat_q == LAST_BEAT)) begin
                    state_d = ST_ARB;
                end else if (!in_tvalid[grant_q] && can_take) begin
                    state_d = ST_ARB;
                end else if (starve_release) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_ARB;
            grant_q     <= ID_W'(N_IN - 1);
            beat_q      <= '0;
            thr_cnt_q   <= '0;
            throttled_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            beat_q      <= beat_d;
            thr_cnt_q   <= thr_cnt_d;
            throttled_q <= ({1'b0, fifo_count} >= THROTTLE_AT);
        end
    end

    // Single output stage: a held beat is only replaced once the FIFO has taken it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tid_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= lane[grant_q];
            out_tid_q   <= grant_q;
        end else if (fifo_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign fifo_tvalid = out_valid_q;
    assign fifo_tdata  = out_data_q;
    assign fifo_tid    = out_tid_q;
    assign grant_idx   = grant_q;
    assign throttled   = throttled_q;

`ifdef STREAM_ARB_STATS_EN
    logic [31:0] stat_q [N_IN];
    logic [31:0] thr_cycles_q;

    // Saturating counters so long runs never wrap back to small values.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < N_IN; i++) begin
                stat_q[i] <= '0;
            end
            thr_cycles_q <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_tvalid[i] && in_tready[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
            if (throttled_q && (thr_cycles_q != '1)) begin
                thr_cycles_q <= thr_cycles_q + 32'd1;
            end
        end
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_stat
        assign beat_cnt_all[i*32 +: 32] = stat_q[i];
    end
    assign throttle_cycles = thr_cycles_q;
`endif

endmodule

// File: tb/tb_stream_fifo_rr_arbiter.sv
// Directed bench for stream_fifo_rr_arbiter: cycle vector table plus burst, stall, drop and reset sequences.
module tb_stream_fifo_rr_arbiter;

    localparam int N_IN  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 14;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_IN*WIDTH-1:0] inTdata;
    logic [N_IN-1:0]       inTvalid;
    logic [N_IN-1:0]       inTready;
    logic [WIDTH-1:0]      fifoTdata;
    logic [ID_W-1:0]       fifoTid;
    logic                  fifoTvalid;
    logic                  fifoTready;
    logic [CNT_W-1:0]      fifoCount;
    logic [ID_W-1:0]       grantIdx;
    logic                  throttled;
`ifdef STREAM_ARB_STATS_EN
    logic [N_IN*32-1:0]    beatCntAll;
    logic [31:0]           throttleCycles;
`endif

    stream_fifo_rr_arbiter dut (
        .ap_clk      (clk),
        .ap_rst      (rst),
        .in_tdata    (inTdata),
        .in_tvalid   (inTvalid),
        .in_tready   (inTready),
        .fifo_tdata  (fifoTdata),
        .fifo_tid    (fifoTid),
        .fifo_tvalid (fifoTvalid),
        .fifo_tready (fifoTready),
        .fifo_count  (fifoCount),
        .grant_idx   (grantIdx),
        .throttled   (throttled)
`ifdef STREAM_ARB_STATS_EN
        ,
        .beat_cnt_all    (beatCntAll),
        .throttle_cycles (throttleCycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic        ready;
        logic [13:0] count;
        logic [3:0]  expReady;
        logic        expValid;
        logic [1:0]  expTid;
        logic [7:0]  expData;
        logic        expThr;
        logic [1:0]  expGrant;
    } vec_t;

    vec_t vecs [20];

    int checks = 0;
    int passes = 0;
    int laneCnt [4];
    int expCnt [4];
    int accTotal;
    int popTotal;

    logic [3:0] sReady;
    logic       sValid;
    logic [1:0] sTid;
    logic [7:0] sData;
    logic       sThr;
    logic [1:0] sGrant;
    logic [3:0] sHs;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearScoreboard();
        for (int l = 0; l < 4; l++) begin
            laneCnt[l] = 0;
            expCnt[l]  = 0;
        end
        accTotal = 0;
        popTotal = 0;
    endtask

    // One clock: drive at negedge, sample just after, score FIFO pops, then count accepted beats.
    task automatic applyStimulus(input logic [3:0] valid, input logic ready, input logic [13:0] count);
        @(negedge clk);
        inTvalid   = valid;
        fifoTready = ready;
        fifoCount  = count;
        for (int l = 0; l < 4; l++) begin
            inTdata[l*8 +: 8] = {2'(l), 6'(laneCnt[l])};
        end
        #1;
        sReady = inTready;
        sValid = fifoTvalid;
        sTid   = fifoTid;
        sData  = fifoTdata;
        sThr   = throttled;
        sGrant = grantIdx;
        sHs    = inTvalid & inTready;
        if (sValid && ready) begin
            checkOutput("scoreboard data", 32'(sData), 32'({sTid, 6'(expCnt[sTid])}));
            expCnt[sTid]++;
            popTotal++;
        end
        @(posedge clk);
        for (int l = 0; l < 4; l++) begin
            if (sHs[l]) begin
                laneCnt[l]++;
                accTotal++;
            end
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst        = 1'b1;
        inTvalid   = '0;
        fifoTready = 1'b1;
        fifoCount  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearScoreboard();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] lfsr;
        logic       rdy;
        logic       prevValid;
        logic       prevReady;
        logic [7:0] prevData;
        logic [1:0] prevTid;
        int         dropAt;
        int         lastGrant;
        int         grantLog [$];
        int         expGrants [5];
        logic [3:0] v;

        rst        = 1'b1;
        inTvalid   = '0;
        inTdata    = '0;
        fifoTready = 1'b1;
        fifoCount  = '0;
        clearScoreboard();

        //             valid    rdy   count    expRdy  eV    tid    data   thr   grant
        vecs[0]  = '{4'b0000, 1'b1, 14'd0,     4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd3};
        vecs[1]  = '{4'b0010, 1'b1, 14'd0,     4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd3};
        vecs[2]  = '{4'b0010, 1'b1, 14'd0,     4'b0010, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1};
        vecs[3]  = '{4'b0010, 1'b1, 14'd16380, 4'b0010, 1'b1, 2'd1, 8'h40, 1'b0, 2'd1};
        vecs[4]  = '{4'b0010, 1'b1, 14'd16380, 4'b0000, 1'b1, 2'd1, 8'h41, 1'b1, 2'd1};
        vecs[5]  = '{4'b0010, 1'b1, 14'd16379, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1};
        vecs[6]  = '{4'b0010, 1'b1, 14'd16379, 4'b0010, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1};
        vecs[7]  = '{4'b0100, 1'b1, 14'd0,     4'b0010, 1'b1, 2'd1, 8'h42, 1'b0, 2'd1};
        vecs[8]  = '{4'b0100, 1'b1, 14'd0,     4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd1};
        vecs[9]  = '{4'b0100, 1'b0, 14'd0,     4'b0100, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2};
        vecs[10] = '{4'b0100, 1'b0, 14'd0,     4'b0000, 1'b1, 2'd2, 8'h80, 1'b0, 2'd2};
        vecs[11] = '{4'b0100, 1'b0, 14'd0,     4'b0000, 1'b1, 2'd2, 8'h80, 1'b0, 2'd2};
        vecs[12] = '{4'b0100, 1'b1, 14'd0,     4'b0100, 1'b1, 2'd2, 8'h80, 1'b0, 2'd2};
        vecs[13] = '{4'b1000, 1'b1, 14'd0,     4'b0100, 1'b1, 2'd2, 8'h81, 1'b0, 2'd2};
        vecs[14] = '{4'b1001, 1'b1, 14'd0,     4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2};
        vecs[15] = '{4'b1001, 1'b1, 14'd0,     4'b1000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd3};
        vecs[16] = '{4'b0001, 1'b1, 14'd0,     4'b1000, 1'b1, 2'd3, 8'hC0, 1'b0, 2'd3};
        vecs[17] = '{4'b0001, 1'b1, 14'd0,     4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd3};
        vecs[18] = '{4'b0000, 1'b1, 14'd0,     4'b0001, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0};
        vecs[19] = '{4'b0000, 1'b1, 14'd0,     4'b0000, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0};

        $display("[TB] vector table: throttle, idle release, stall");
        resetDut();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].ready, vecs[i].count);
            checkOutput($sformatf("vec%0d in_tready", i), 32'(sReady), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d fifo_tvalid", i), 32'(sValid), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d grant_idx", i), 32'(sGrant), 32'(vecs[i].expGrant));
            checkOutput($sformatf("vec%0d throttled", i), 32'(sThr), 32'(vecs[i].expThr));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d fifo_tid", i), 32'(sTid), 32'(vecs[i].expTid));
                checkOutput($sformatf("vec%0d fifo_tdata", i), 32'(sData), 32'(vecs[i].expData));
            end
        end

        // All four lanes busy: 16-beat bursts in order 0,1,2,3,0 with one idle slot between.
        $display("[TB] all lanes valid, full rotation");
        resetDut();
        for (int n = 0; n < 91; n++) begin
            applyStimulus(4'hF, 1'b1, 14'd0);
            if (n < 2) begin
                checkOutput($sformatf("rot%0d tvalid", n), 32'(sValid), 32'd0);
            end else begin
                checkOutput($sformatf("rot%0d tvalid", n), 32'(sValid), 32'(((n - 2) % 17) < 16));
                if (((n - 2) % 17) < 16) begin
                    checkOutput($sformatf("rot%0d tid", n), 32'(sTid), 32'(((n - 2) / 17) % 4));
                end
            end
        end

        $display("[TB] single requester 2");
        resetDut();
        for (int n = 0; n < 41; n++) begin
            applyStimulus(4'b0100, 1'b1, 14'd0);
            if (n < 2) begin
                checkOutput($sformatf("solo%0d tvalid", n), 32'(sValid), 32'd0);
            end else begin
                checkOutput($sformatf("solo%0d tvalid", n), 32'(sValid), 32'(((n - 2) % 17) < 16));
                if (((n - 2) % 17) < 16) begin
                    checkOutput($sformatf("solo%0d tid", n), 32'(sTid), 32'd2);
                end
            end
        end
        checkOutput("solo accepted beats", 32'(accTotal), 32'd38);
        checkOutput("solo popped beats", 32'(popTotal), 32'd37);

        $display("[TB] random fifo_tready backpressure");
        resetDut();
        lfsr      = 8'hA5;
        prevValid = 1'b0;
        prevReady = 1'b1;
        prevData  = '0;
        prevTid   = '0;
        for (int n = 0; n < 200; n++) begin
            rdy  = lfsr[0];
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            applyStimulus(4'hF, rdy, 14'd0);
            if (prevValid && !prevReady) begin
                checkOutput($sformatf("stall%0d tvalid held", n), 32'(sValid), 32'd1);
                checkOutput($sformatf("stall%0d tdata held", n), 32'(sData), 32'(prevData));
                checkOutput($sformatf("stall%0d tid held", n), 32'(sTid), 32'(prevTid));
            end
            prevValid = sValid;
            prevReady = rdy;
            prevData  = sData;
            prevTid   = sTid;
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(4'h0, 1'b1, 14'd0);
        end
        checkOutput("stall no beat lost", 32'(popTotal), 32'(accTotal));

        $display("[TB] requester 1 drops valid after 5 beats");
        resetDut();
        dropAt    = -1;
        lastGrant = 4;
        grantLog.delete();
        expGrants = '{3, 1, 2, 3, 1};
        for (int n = 0; n < 60; n++) begin
            if (dropAt < 0 && laneCnt[1] == 5) begin
                dropAt = n;
                v = 4'b1100;
            end else begin
                v = 4'b1110;
            end
            applyStimulus(v, 1'b1, 14'd0);
            if (int'(sGrant) != lastGrant) begin
                grantLog.push_back(int'(sGrant));
                lastGrant = int'(sGrant);
            end
            if (dropAt >= 0 && n == dropAt + 2) begin
                checkOutput("grant right after drop", 32'(sGrant), 32'd2);
            end
        end
        checkOutput("drop happened", 32'(dropAt), 32'd6);
        checkOutput("grant log length", 32'(grantLog.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < grantLog.size()) begin
                checkOutput($sformatf("grant order %0d", i), 32'(grantLog[i]), 32'(expGrants[i]));
            end
        end

        // Reset in mid-burst with the count at the throttle level during the reset cycle.
        $display("[TB] reset mid-burst");
        resetDut();
        for (int n = 0; n < 10; n++) begin
            applyStimulus(4'hF, 1'b1, 14'd0);
        end
        @(negedge clk);
        rst       = 1'b1;
        fifoCount = 14'd16380;
        #1;
        checkOutput("in_tready during reset", 32'(inTready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        fifoCount = 14'd0;
        #1;
        checkOutput("post-reset fifo_tvalid", 32'(fifoTvalid), 32'd0);
        checkOutput("post-reset fifo_tdata", 32'(fifoTdata), 32'd0);
        checkOutput("post-reset fifo_tid", 32'(fifoTid), 32'd0);
        checkOutput("post-reset throttled", 32'(throttled), 32'd0);
        checkOutput("post-reset grant_idx", 32'(grantIdx), 32'd3);
        checkOutput("post-reset in_tready", 32'(inTready), 32'd0);
`ifdef STREAM_ARB_STATS_EN
        for (int l = 0; l < 4; l++) begin
            checkOutput($sformatf("post-reset beat_cnt_all[%0d]", l), beatCntAll[l*32 +: 32], 32'd0);
        end
        checkOutput("post-reset throttle_cycles", throttleCycles, 32'd0);
`endif
        clearScoreboard();
        applyStimulus(4'hF, 1'b1, 14'd0);
        applyStimulus(4'hF, 1'b1, 14'd0);
        checkOutput("first grant after reset", 32'(sGrant), 32'd0);
        checkOutput("first ready after reset", 32'(sReady), 32'b0001);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stream_fifo_rr_arbiter.md
Name: stream_fifo_rr_arbiter

Overview:
- Shares one StreamingFIFO input port between N_IN AXI-Stream producers using round-robin arbitration with burst-limited grants.
- Drives the FIFO's TDATA/TVALID/TREADY and reads the FIFO's count output to apply almost-full throttling.
- Emits a source-ID sideband so downstream logic can demultiplex.
- Sits between parallel MVAU/SWG output lanes and a single deep Q_srl FIFO.

Parameters:
- N_IN, 4, number of requesters (2..16)
- WIDTH, 8, data width per beat
- DEPTH, 16384, depth of the downstream FIFO
- CNT_W, 14, width of fifo_count
- BURST_LEN, 16, maximum beats per grant before forced rotation
- HEADROOM, 4, free-entry margin; throttle when fifo_count >= DEPTH-HEADROOM
- ID_W, 2, width of source ID; equals clog2(N_IN)

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  synchronous active-high reset
- in_tdata  in  N_IN*WIDTH  packed requester data; lane i at [i*WIDTH +: WIDTH]
- in_tvalid  in  N_IN  per-requester valid
- in_tready  out  N_IN  per-requester ready; one-hot or zero
- fifo_tdata  out  WIDTH  to FIFO in0_V_V_TDATA
- fifo_tid  out  ID_W  source index of current fifo_tdata beat
- fifo_tvalid  out  1  to FIFO in0_V_V_TVALID
- fifo_tready  in  1  from FIFO in0_V_V_TREADY
- fifo_count  in  CNT_W  FIFO occupancy
- grant_idx  out  ID_W  current/last granted requester
- throttled  out  1  high while the almost-full throttle is active

Behaviour:
- Decided: one clock; reset is synchronous and active-high.
- Reset values: in_tready=0, fifo_tvalid=0, fifo_tdata=0, fifo_tid=0, throttled=0, grant_idx=N_IN-1 (so requester 0 has first priority), state=ARB, beat_cnt=0.
- Output register: single stage. out_free = !fifo_tvalid || fifo_tready. A beat is accepted from requester g when in_tvalid[g] && in_tready[g]. It appears on fifo_* the next cycle: latency 1 cycle, no bubbles at full throughput.
- throttled (registered) = (fifo_count >= DEPTH-HEADROOM); compare at CNT_W+1 bits to avoid wrap.
- in_tready[g] = (state==GRANT) && out_free && !throttled. All other bits are 0.
- fifo_tvalid stays asserted while fifo_tready=0. Data and tid hold stable (AXI-S rule).
- States:
  - ARB: search indices (grant_idx+1..grant_idx+N_IN) mod N_IN for the first set in_tvalid. If one is found: grant_idx<=that index, beat_cnt<=0, go to GRANT. If none: stay in ARB. ARB costs exactly one cycle per grant.
  - GRANT: on each accepted beat, beat_cnt++. Go to ARB when any of these holds:
    - a beat is accepted with beat_cnt==BURST_LEN-1;
    - in_tvalid[grant_idx]=0 while out_free && !throttled (requester idle);
    - throttled has been held for more than BURST_LEN consecutive cycles (starvation release).
- Throttle does not drop a beat already in the output register; it only blocks new acceptance.
- Single requester active: it regains the grant after each ARB cycle, giving max throughput BURST_LEN/(BURST_LEN+1).
- A requester deasserting valid mid-grant releases the grant; no data is lost.
- Reset mid-operation: the in-flight output beat is discarded; a transient upstream-side beat is never accepted because in_tready=0 in the reset cycle.
- N_IN not a power of two: the wrap uses an explicit compare, never bit truncation.

Optional Feature:
- Macro: STREAM_ARB_STATS_EN.
- Defined: adds output port beat_cnt_all (N_IN*32 bits), one saturating 32-bit counter per requester, incremented per accepted beat and cleared by ap_rst. Also adds a 32-bit throttle_cycles counter.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package stream_arb_pkg: state enum (ARB, GRANT), a clog2-based ID_W helper, and the localparam THROTTLE_LVL = DEPTH-HEADROOM.
- Sub-module rr_pick: combinational round-robin priority search over N_IN requests with a start pointer. Outputs found and idx. Reusable by other lane mergers.

Test Plan:
- Reset, then all 4 in_tvalid high, fifo_tready=1, fifo_count=0 -> grants go 0,1,2,3,0. Each grant passes exactly 16 beats with matching fifo_tid, followed by one ARB bubble cycle.
- Only requester 2 valid, continuous -> 16 beats, 1 bubble, 16 beats; every fifo_tid=2; no beat loss or duplication (scoreboard).
- fifo_tready toggling 1/0 pseudo-randomly -> fifo_tdata/fifo_tid stable while stalled; in-order per-source data; no beat dropped.
- fifo_count driven to 16380 -> throttled=1 on the next cycle, in_tready all 0. Count returns to 16379 -> acceptance resumes from the same grant.
- Requester 1 drops valid after 5 beats -> arbiter enters ARB and grants requester 2 the next cycle; requester 1 is revisited only after 2 and 3.
- Assert ap_rst for one cycle mid-burst -> all outputs at reset values the following cycle; the first grant after reset goes to requester 0. With STREAM_ARB_STATS_EN, the counters read 0.
